// File: rtl/mul_seq_approx_et.sv
// Sequential shift-add multiplier producing exact and column-truncated products in parallel,
// with error magnitude, threshold flag and a saturating counter of flagged approximate results.
module mul_seq_approx_et #(
    parameter int WIDTH     = 4,
    parameter int DROP_COLS = 2,
    parameter int ET        = 8,
    parameter int CNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_a,
    input  logic [WIDTH-1:0]       in_b,
    input  logic                   approx_en,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*WIDTH-1:0]     out_prod,
    output logic [2*WIDTH-1:0]     err_mag,
    output logic                   err_flag,
    output logic [CNT_WIDTH-1:0]   err_count
);

    localparam int PW = 2 * WIDTH;
    localparam int KW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [PW-1:0] KEEP_MASK = {{(PW - DROP_COLS){1'b1}}, {DROP_COLS{1'b0}}};
    localparam logic [PW-1:0] ET_V      = PW'(ET);
    localparam logic [KW-1:0] K_LAST    = KW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic                 apx_q, apx_d;
    logic [PW-1:0]        accExact_q, accExact_d;
    logic [PW-1:0]        accApx_q, accApx_d;
    logic [KW-1:0]        k_q, k_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic [PW-1:0] partial;
    logic [PW-1:0] errRaw;
    logic          flagRaw;

    assign partial = PW'(a_q) << k_q;
    assign errRaw  = accExact_q - accApx_q;
    assign flagRaw = errRaw > ET_V;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            apx_q      <= 1'b0;
            accExact_q <= '0;
            accApx_q   <= '0;
            k_q        <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            apx_q      <= apx_d;
            accExact_q <= accExact_d;
            accApx_q   <= accApx_d;
            k_q        <= k_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        apx_d      = apx_q;
        accExact_d = accExact_q;
        accApx_d   = accApx_q;
        k_d        = k_q;
        cnt_d      = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d        = in_a;
                    b_d        = in_b;
                    apx_d      = approx_en;
                    accExact_d = '0;
                    accApx_d   = '0;
                    k_d        = '0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                // Truncation is applied per partial product, so the error accumulates column-wise.
                if (b_q[k_q]) begin
                    accExact_d = accExact_q + partial;
                    accApx_d   = accApx_q + (partial & KEEP_MASK);
                end
                k_d = k_q + 1'b1;
                if (k_q == K_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                    if (flagRaw && apx_q && (cnt_q != {CNT_WIDTH{1'b1}})) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_prod  = (state_q == DONE) ? (apx_q ? accApx_q : accExact_q) : '0;
    assign err_mag   = (state_q == DONE) ? errRaw : '0;
    assign err_flag  = (state_q == DONE) && flagRaw;
    assign err_count = cnt_q;

endmodule

// File: doc/mul_seq_approx_et.md
# mul_seq_approx_et

Parametrised sequential unsigned multiplier with run-time selectable column-truncation approximation and a built-in error monitor. It computes the exact and the approximate product side by side with a shift-add datapath, one partial product per cycle. It returns the selected product together with the error magnitude and an error-threshold flag. It is the clocked, width-generic successor to the fixed 2x2 approximate multiplier netlists and sits between an operand source and a result sink, with valid/ready handshakes on both sides.

## Interface
- WIDTH, 4: operand width in bits, at least 2.
- DROP_COLS, 2: number of least-significant product columns discarded in approximate mode, 1..WIDTH.
- ET, 8: error threshold. `err_flag` asserts when the error exceeds ET.
- CNT_WIDTH, 8: width of the saturating error-event counter.
- clk  in  1  clock. All state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands.
- in_a  in  WIDTH  multiplicand, unsigned.
- in_b  in  WIDTH  multiplier, unsigned.
- approx_en  in  1  mode, sampled with the operands. 1 selects the approximate product, 0 the exact product.
- out_valid  out  1  result valid.
- out_ready  in  1  sink accepts result.
- out_prod  out  2*WIDTH  selected product.
- err_mag  out  2*WIDTH  exact minus approximate. Always computed, in both modes.
- err_flag  out  1  err_mag > ET.
- err_count  out  CNT_WIDTH  number of delivered results with err_flag=1 and approx_en=1, saturating.

## Operation
- FSM has three states: IDLE, RUN, DONE. `in_ready` = (state==IDLE). `out_valid` = (state==DONE).
- **IDLE:** on in_valid & in_ready, latch in_a, in_b and approx_en; clear acc_exact, acc_apx and the bit counter k; go to RUN. in_valid=0 stays in IDLE.
- **RUN:** each edge handles bit k of the latched b.
  - If b[k]=1: acc_exact += a<<k; acc_apx += (a<<k) with bits [DROP_COLS-1:0] forced to 0.
  - k increments. After the edge that processes k=WIDTH-1, go to DONE.
  - Accumulators are 2*WIDTH bits wide; no overflow is possible.
- **DONE:** outputs are driven as follows.
  - out_prod = latched approx_en ? acc_apx : acc_exact.
  - err_mag = acc_exact - acc_apx. This is never negative, because truncation only removes bits.
  - err_flag = (err_mag > ET).
  - All outputs stay stable while out_ready=0.
  - On out_ready=1: go to IDLE. If err_flag & approx_en, err_count increments, saturating at all-ones.
- in_valid during RUN or DONE is ignored, since in_ready=0. Operands that change after acceptance have no effect.
- **Reset (asynchronous, any time including mid-RUN):**
  - state=IDLE, accumulators, k and err_count cleared, so in_ready=1 and out_valid=0 immediately.
  - out_prod, err_mag and err_flag read 0. The in-flight operation is discarded and not counted.
- out_prod, err_mag and err_flag are registered or decoded from registered state only, with no combinational path from inputs. in_ready and out_valid are decoded from state.

## Timing
- Accept edge is T0. RUN edges are T1..TWIDTH. out_valid is high from after TWIDTH, giving a latency of WIDTH cycles.
- Minimum initiation interval is WIDTH+2 cycles: accept, WIDTH RUN cycles, one DONE cycle with out_ready=1, then back in IDLE for the next accept.
- Backpressure is unlimited: DONE holds indefinitely.
- The err_count update and the DONE→IDLE transition occur on the same edge as the output handshake.

## Test plan
- **Reset values:** assert rst mid-RUN (WIDTH=4, a=9, b=7).
  - in_ready=1 and out_valid=0 asynchronously. out_prod=0, err_count=0.
  - No result is emitted after deassertion.
- **Exact mode:** a=15, b=15, approx_en=0.
  - out_valid after exactly 4 cycles; out_prod=225, err_mag=5, err_flag=0, err_count unchanged.
- **Approximate mode:** a=6, b=5, approx_en=1, with defaults.
  - out_prod=28, err_mag=2, err_flag=0.
  - a=15, b=15 gives out_prod=220, err_mag=5.
- **Threshold:** ET=3, approx_en=1, a=15, b=15 gives err_flag=1 and err_count increments to 1.
  - a=3, b=1 gives out_prod=0, err_mag=3, err_flag=0 (the boundary value is not flagged).
- **Backpressure:** hold out_ready=0 for 10 cycles.
  - Outputs stay stable and in_valid is ignored.
  - When out_ready is raised, exactly one transfer occurs and in_ready=1 on the next cycle.
- **Saturation and sweep:** use CNT_WIDTH=2, ET=0 and 5 flagged approximate results.
  - err_count sticks at 3.
  - Run an exhaustive 4-bit sweep in both modes against a reference model.
